// File: rtl/instr_fetch_issue.sv
// Fetch/issue front end: holds the PC, fetches one MIPS word per req/ack
// handshake, issues it to execute and resolves the next PC on accept.
module instr_fetch_issue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [5:0]  funct,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic [1:0]  branch,
    input  logic        zero,
    output logic [31:0] pc,
    output logic [31:0] link_pc,
    output logic [31:0] retired
);

    typedef enum logic {FETCH, ISSUE} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] retired_q, retired_d;
    logic [31:0] br_off;
    logic [31:0] next_pc;
    logic        br_taken;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= FETCH;
            pc_q      <= RESET_PC;
            instr_q   <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            retired_q <= retired_d;
        end
    end

    assign link_pc  = pc_q + 32'd4;
    assign br_off   = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    assign br_taken = (branch == 2'b10 && zero) || (branch == 2'b01 && !zero);

    always_comb begin
        next_pc = link_pc;
        if (branch == 2'b11)
            next_pc = {link_pc[31:28], instr_q[25:0], 2'b00};
        else if (br_taken)
            next_pc = link_pc + br_off;
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        retired_d = retired_q;
        case (state_q)
            FETCH: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // Ack is ignored here; branch/zero only matter in the accept cycle.
                if (instr_ready) begin
                    pc_d      = {next_pc[31:2], 2'b00};
                    retired_d = retired_q + 32'd1;
                    state_d   = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    // Request is masked during reset so it first rises the cycle after release.
    assign imem_req    = (state_q == FETCH) && !reset;
    assign imem_addr   = pc_q;
    assign instr_valid = (state_q == ISSUE);
    assign instr       = instr_q;
    assign opcode      = instr_q[31:26];
    assign funct       = instr_q[5:0];
    assign pc          = pc_q;
    assign retired     = retired_q;

endmodule
